// File: rtl/gate_scheduler_pkg.sv
// Shared types and default widths for the gate scheduler and its counters.
package gate_scheduler_pkg;

  localparam int S_DEFAULT    = 20;
  localparam int CC_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_CFG = 3'd2,
    ISSUE    = 3'd3,
    SWAP     = 3'd4,
    FINISH   = 3'd5
  } sched_state_t;

endpackage

// File: rtl/gate_scheduler_counter.sv
// Loadable, enabled up-counter that also reports when it sits on a terminal value.
module sched_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_val_i,
  output logic [W-1:0] count_o,
  output logic         term_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load takes priority over increment so a sweep restart always wins.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == term_val_i);

endmodule

// File: rtl/gate_scheduler.sv
// Sequences the netlist header read, then sweeps gate IDs once per sequential cycle,
// pulsing dff_swap between sweeps and done after the final one.
module gate_scheduler
  import gate_scheduler_pkg::*;
#(
  parameter int S    = S_DEFAULT,
  parameter int CC_W = CC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CC_W-1:0] num_cc,
  output logic            nl_start,
  input  logic            nl_done,
  input  logic [S-1:0]    nl_gate_size,
  output logic [S-1:0]    gid,
  output logic            gate_valid,
  input  logic            gate_ready,
  output logic            gate_last,
  output logic [CC_W-1:0] cc_idx,
  output logic            cc_last,
  output logic            dff_swap,
  output logic            busy,
  output logic            done
);

  sched_state_t    state_q, state_d;
  logic            cfgValid_q, cfgValid_d;
  logic [S-1:0]    gsize_q, gsize_d;
  logic [CC_W-1:0] ncc_q, ncc_d;

  logic            gidLoad, gidEn, gidTerm;
  logic            ccLoad, ccEn, ccTerm;
  logic [S-1:0]    gidCount;
  logic [CC_W-1:0] ccCount;

  sched_counter #(.W(S)) u_gate_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gidLoad),
    .load_val_i ('0),
    .en_i       (gidEn),
    .term_val_i (gsize_q - S'(1)),
    .count_o    (gidCount),
    .term_o     (gidTerm)
  );

  sched_counter #(.W(CC_W)) u_cycle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ccLoad),
    .load_val_i ('0),
    .en_i       (ccEn),
    .term_val_i (ncc_q - CC_W'(1)),
    .count_o    (ccCount),
    .term_o     (ccTerm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cfgValid_q <= 1'b0;
      gsize_q    <= '0;
      ncc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cfgValid_q <= cfgValid_d;
      gsize_q    <= gsize_d;
      ncc_q      <= ncc_d;
    end
  end

  // The header is only read once per reset; the reader never restarts it.
  always_comb begin
    state_d    = state_q;
    cfgValid_d = cfgValid_q;
    gsize_d    = gsize_q;
    ncc_d      = ncc_q;
    nl_start   = 1'b0;
    gate_valid = 1'b0;
    gate_last  = 1'b0;
    cc_last    = 1'b0;
    dff_swap   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    gidLoad    = 1'b0;
    gidEn      = 1'b0;
    ccLoad     = 1'b0;
    ccEn       = 1'b0;

    unique case (state_q)
      IDLE: begin
        gidLoad = 1'b1;
        ccLoad  = 1'b1;
        if (start) begin
          ncc_d = (num_cc == '0) ? CC_W'(1) : num_cc;
          if (!cfgValid_q) begin
            state_d = LOAD;
          end else if (gsize_q == '0) begin
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      LOAD: begin
        busy     = 1'b1;
        nl_start = 1'b1;
        state_d  = WAIT_CFG;
      end
      WAIT_CFG: begin
        busy = 1'b1;
        if (nl_done) begin
          gsize_d    = nl_gate_size;
          cfgValid_d = 1'b1;
          state_d    = (nl_gate_size == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        busy       = 1'b1;
        gate_valid = 1'b1;
        gate_last  = gidTerm;
        cc_last    = ccTerm;
        // gid must not move during a stall; the reader decodes it combinationally.
        if (gate_ready) begin
          if (!gidTerm) begin
            gidEn = 1'b1;
          end else if (ccTerm) begin
            state_d = FINISH;
          end else begin
            state_d = SWAP;
          end
        end
      end
      SWAP: begin
        busy     = 1'b1;
        dff_swap = 1'b1;
        gidLoad  = 1'b1;
        ccEn     = 1'b1;
        state_d  = ISSUE;
      end
      FINISH: begin
        done    = 1'b1;
        gidLoad = 1'b1;
        ccLoad  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gid    = gidCount;
  assign cc_idx = ccCount;

endmodule

// File: tb/tb_gate_scheduler.sv
// Directed bench for gate_scheduler: header load, sweeps, backpressure, reuse and reset.
module tb_gate_scheduler;

  localparam int S    = 20;
  localparam int CC_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CC_W-1:0] num_cc;
  logic            nl_start;
  logic            nl_done;
  logic [S-1:0]    nl_gate_size;
  logic [S-1:0]    gid;
  logic            gate_valid;
  logic            gate_ready;
  logic            gate_last;
  logic [CC_W-1:0] cc_idx;
  logic            cc_last;
  logic            dff_swap;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;

  int hsCnt = 0, swapCnt = 0, doneCnt = 0, nlStartCnt = 0, validCnt = 0;
  int hsBase, swapBase, doneBase, nlStartBase, validBase;

  gate_scheduler #(.S(S), .CC_W(CC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_cc       (num_cc),
    .nl_start     (nl_start),
    .nl_done      (nl_done),
    .nl_gate_size (nl_gate_size),
    .gid          (gid),
    .gate_valid   (gate_valid),
    .gate_ready   (gate_ready),
    .gate_last    (gate_last),
    .cc_idx       (cc_idx),
    .cc_last      (cc_last),
    .dff_swap     (dff_swap),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the active edge, i.e. what the DUT actually committed.
  always @(posedge clk) begin
    if (gate_valid && gate_ready) hsCnt <= hsCnt + 1;
    if (dff_swap) swapCnt <= swapCnt + 1;
    if (done) doneCnt <= doneCnt + 1;
    if (nl_start) nlStartCnt <= nlStartCnt + 1;
    if (gate_valid) validCnt <= validCnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot();
    hsBase      = hsCnt;
    swapBase    = swapCnt;
    doneBase    = doneCnt;
    nlStartBase = nlStartCnt;
    validBase   = validCnt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [CC_W-1:0] ncc, input logic rdy);
    start      = st;
    num_cc     = ncc;
    gate_ready = rdy;
    step();
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_nl_start"}, 32'(nl_start), 0);
    checkOutput({tag, "_gate_valid"}, 32'(gate_valid), 0);
    checkOutput({tag, "_gid"}, 32'(gid), 0);
    checkOutput({tag, "_gate_last"}, 32'(gate_last), 0);
    checkOutput({tag, "_cc_idx"}, 32'(cc_idx), 0);
    checkOutput({tag, "_cc_last"}, 32'(cc_last), 0);
    checkOutput({tag, "_dff_swap"}, 32'(dff_swap), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
  endtask

  // Entered in the LOAD cycle; the reader model answers 3 cycles after nl_start.
  task automatic headerPhase(input logic [S-1:0] gs);
    checkOutput("nl_start_pulse", 32'(nl_start), 1);
    checkOutput("busy_in_load", 32'(busy), 1);
    step();
    checkOutput("nl_start_one_cycle", 32'(nl_start), 0);
    step();
    step();
    checkOutput("no_valid_in_wait", 32'(gate_valid), 0);
    nl_done      = 1'b1;
    nl_gate_size = gs;
    step();
    nl_done      = 1'b0;
    nl_gate_size = '0;
  endtask

  task automatic checkSweep(input int n, input int cc, input logic ccl);
    gate_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      checkOutput("sweep_valid", 32'(gate_valid), 1);
      checkOutput("sweep_gid", 32'(gid), 32'(i));
      checkOutput("sweep_gate_last", 32'(gate_last), 32'(i == n - 1));
      checkOutput("sweep_cc_idx", 32'(cc_idx), 32'(cc));
      checkOutput("sweep_cc_last", 32'(cc_last), 32'(ccl));
      checkOutput("sweep_no_swap", 32'(dff_swap), 0);
      step();
    end
  endtask

  task automatic doReset();
    rst        = 1'b1;
    start      = 1'b0;
    gate_ready = 1'b0;
    nl_done    = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    num_cc       = '0;
    nl_done      = 1'b0;
    nl_gate_size = '0;
    gate_ready   = 1'b0;

    // Reset state
    doReset();
    checkAllZero("reset");

    // Basic run: num_cc=1, gate_size=5
    snapshot();
    applyStimulus(1'b1, 16'd1, 1'b1);
    headerPhase(20'd5);
    checkSweep(5, 0, 1'b1);
    checkOutput("basic_done", 32'(done), 1);
    checkOutput("basic_busy_drop", 32'(busy), 0);
    step();
    checkOutput("basic_done_one_cycle", 32'(done), 0);
    checkOutput("basic_no_swap", 32'(swapCnt - swapBase), 0);
    checkOutput("basic_handshakes", 32'(hsCnt - hsBase), 5);

    // Backpressure: gate_size=4, ready low 3 cycles at gid 2
    doReset();
    snapshot();
    applyStimulus(1'b1, 16'd1, 1'b1);
    headerPhase(20'd4);
    checkOutput("bp_gid0", 32'(gid), 0);
    step();
    checkOutput("bp_gid1", 32'(gid), 1);
    step();
    gate_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_stall_gid", 32'(gid), 2);
      checkOutput("bp_stall_valid", 32'(gate_valid), 1);
      checkOutput("bp_stall_last", 32'(gate_last), 0);
      step();
    end
    gate_ready = 1'b1;
    checkOutput("bp_resume_gid", 32'(gid), 2);
    step();
    checkOutput("bp_gid3", 32'(gid), 3);
    checkOutput("bp_gid3_last", 32'(gate_last), 1);
    step();
    checkOutput("bp_done", 32'(done), 1);
    checkOutput("bp_handshakes", 32'(hsCnt - hsBase), 4);
    step();

    // Multi-cycle: num_cc=3, gate_size=2
    doReset();
    snapshot();
    applyStimulus(1'b1, 16'd3, 1'b1);
    headerPhase(20'd2);
    for (int c = 0; c < 3; c++) begin
      checkSweep(2, c, 1'(c == 2));
      if (c < 2) begin
        checkOutput("mc_swap", 32'(dff_swap), 1);
        checkOutput("mc_swap_no_valid", 32'(gate_valid), 0);
        checkOutput("mc_swap_busy", 32'(busy), 1);
        step();
      end
    end
    checkOutput("mc_done", 32'(done), 1);
    step();
    checkOutput("mc_swap_count", 32'(swapCnt - swapBase), 2);
    checkOutput("mc_done_count", 32'(doneCnt - doneBase), 1);

    // Degenerate: gate_size=0, num_cc=4
    doReset();
    snapshot();
    applyStimulus(1'b1, 16'd4, 1'b1);
    headerPhase(20'd0);
    checkOutput("gs0_done", 32'(done), 1);
    checkOutput("gs0_no_valid_now", 32'(gate_valid), 0);
    step();
    checkOutput("gs0_valid_count", 32'(validCnt - validBase), 0);
    checkOutput("gs0_swap_count", 32'(swapCnt - swapBase), 0);

    // Degenerate: num_cc=0 behaves as 1, gate_size=3
    doReset();
    applyStimulus(1'b1, 16'd0, 1'b1);
    headerPhase(20'd3);
    checkSweep(3, 0, 1'b1);
    checkOutput("ncc0_done", 32'(done), 1);
    step();

    // Reuse: second start skips the header read; start mid-run is ignored
    snapshot();
    applyStimulus(1'b1, 16'd2, 1'b1);
    checkOutput("reuse_no_nl_start", 32'(nl_start), 0);
    checkOutput("reuse_valid", 32'(gate_valid), 1);
    checkOutput("reuse_gid0", 32'(gid), 0);
    step();
    checkOutput("reuse_gid1", 32'(gid), 1);
    applyStimulus(1'b1, 16'd5, 1'b1);
    checkOutput("reuse_gid2", 32'(gid), 2);
    checkOutput("reuse_gid2_last", 32'(gate_last), 1);
    checkOutput("reuse_cc0_not_last", 32'(cc_last), 0);
    step();
    checkOutput("reuse_swap", 32'(dff_swap), 1);
    step();
    checkSweep(3, 1, 1'b1);
    checkOutput("reuse_done", 32'(done), 1);
    applyStimulus(1'b1, 16'd1, 1'b1);
    checkOutput("finish_start_ignored_busy", 32'(busy), 0);
    checkOutput("finish_start_ignored_valid", 32'(gate_valid), 0);
    step();
    checkOutput("finish_start_still_idle", 32'(gate_valid), 0);
    checkOutput("reuse_nl_start_count", 32'(nlStartCnt - nlStartBase), 0);

    // Reset mid-run at gid 3 of cc_idx 1
    doReset();
    snapshot();
    applyStimulus(1'b1, 16'd2, 1'b1);
    headerPhase(20'd5);
    checkSweep(5, 0, 1'b0);
    checkOutput("mr_swap", 32'(dff_swap), 1);
    step();
    step();
    step();
    step();
    checkOutput("mr_gid3", 32'(gid), 3);
    checkOutput("mr_cc1", 32'(cc_idx), 1);
    rst = 1'b1;
    step();
    checkAllZero("midreset");
    rst = 1'b0;
    applyStimulus(1'b1, 16'd1, 1'b1);
    headerPhase(20'd2);
    checkSweep(2, 0, 1'b1);
    checkOutput("mr_done", 32'(done), 1);
    step();
    checkOutput("mr_nl_start_count", 32'(nlStartCnt - nlStartBase), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
